fa_1007: RTL and testbench
==========================

Name: fa_1007

Overview:
- Full adder. Sums operands a, b and carry-in c.
- Produces sum s and carry-out cout combinationally, in the same delta, for zero-latency use.
- Also provides a one-cycle registered copy of the result (s_q, cout_q) with a valid flag, so downstream pipelined logic can consume it.
- Leaf arithmetic block; instantiated directly in datapaths or chained via WIDTH.

Parameters:
- WIDTH, 1, bit width of operands a, b and sum s; WIDTH=1 is the classic 1-bit full adder.

Ports:
- clk  input  1  clock; all registers update on its rising edge
- rst  input  1  reset, asynchronous, active-high
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c  input  1  carry-in
- in_valid  input  1  qualifies a/b/c for the registered path
- s  output  WIDTH  combinational sum
- cout  output  1  combinational carry-out
- s_q  output  WIDTH  registered sum
- cout_q  output  1  registered carry-out
- out_valid  output  1  s_q/cout_q hold a result captured from a valid input

Behaviour:
- Combinational path:
  - {cout, s} = a + b + c, computed at WIDTH+1 bits with no truncation of the carry.
  - Implemented as a ripple of 1-bit full-adder cells:
    - s_i = a_i ^ b_i ^ carry_i
    - carry_{i+1} = (a_i & b_i) | (carry_i & (a_i ^ b_i))
    - carry_0 = c; cout = carry_WIDTH.
  - No clock or reset dependency. Outputs follow inputs immediately.
  - An X/Z on any input may propagate to the outputs.
- 1-bit truth table (a b c -> s cout): 000->0 0, 001->1 0, 010->1 0, 011->0 1, 100->1 0, 101->0 1, 110->0 1, 111->1 1.
- Registered path:
  - On a rising clk edge with in_valid=1: s_q <= s, cout_q <= cout, out_valid <= 1.
  - On a rising clk edge with in_valid=0: s_q and cout_q hold their values; out_valid <= 0.
  - Latency is exactly 1 cycle from the sampled input to s_q/cout_q.
  - Throughput is one result per cycle. There is no backpressure.
- Reset:
  - rst=1 forces s_q=0, cout_q=0, out_valid=0 immediately, without waiting for a clock edge.
  - Values are held while rst=1. The combinational s/cout are unaffected by rst.
  - Asserting rst mid-stream discards any captured result.
  - The first valid capture occurs on the first rising edge after rst deasserts with in_valid=1.
- Boundary conditions:
  - Maximum sum: all-ones a, b with c=1 gives s = all-ones and cout = 1.
  - Wrap-around: all-ones a, b=0, c=1 gives s = 0 and cout = 1.
  - Back-to-back valid inputs each produce their own registered result on consecutive cycles.

Test Plan:
- WIDTH=1 exhaustive, no clock needed: apply abc = 000,001,010,011,100,101,110,111 at 5 ns spacing -> s/cout = 0/0,1/0,1/0,0/1,1/0,0/1,0/1,1/1 respectively, within the same timestep.
- Registered latency, WIDTH=1: rst pulse, then a=1 b=1 c=0 with in_valid=1 at edge N -> s_q=0, cout_q=1, out_valid=1 after edge N. Drop in_valid at edge N+1 -> out_valid=0, s_q/cout_q unchanged.
- Async reset: with out_valid=1 and s_q=1, raise rst between clock edges -> s_q=0, cout_q=0, out_valid=0 before the next edge. Combinational s/cout still track the inputs.
- WIDTH=4 carry chain: a=4'hF, b=4'h0, c=1 -> s=4'h0, cout=1. Then a=4'hF, b=4'hF, c=1 -> s=4'hF, cout=1.
- WIDTH=4 random: 200 random a/b/c with in_valid toggling randomly -> combinational {cout,s} equals a+b+c every vector. Registered outputs match the vector from the previous valid cycle; out_valid mirrors the previous in_valid.

Source files
------------

// File: rtl/fa_1007.sv
// rtl/fa_1007.sv - ripple-carry full adder with a combinational result and a one-cycle registered copy
module fa_1007 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             out_valid
);

  logic             ripple_carry;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             valid_d;

  // Ripple of 1-bit full-adder cells; the carry is a procedural variable so the chain is one flat cone
  always_comb begin
    s            = '0;
    ripple_carry = c;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]         = a[i] ^ b[i] ^ ripple_carry;
      ripple_carry = (a[i] & b[i]) | (ripple_carry & (a[i] ^ b[i]));
    end
    cout = ripple_carry;
  end

  // Next state: capture the live result only when the input is qualified, otherwise hold
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      s_d    = s;
      cout_d = cout;
    end
  end

  // Registered copy; reset clears it immediately and discards any captured result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= '0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s_q       <= s_d;
      cout_q    <= cout_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_fa_1007.sv
// tb/tb_fa_1007.sv - directed and random checks of fa_1007 at WIDTH=1 and WIDTH=4
module tb_fa_1007;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, iv1 = 1'b0;
  logic       s1, co1, sq1, coq1, ov1;

  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic       c4 = 1'b0, iv4 = 1'b0;
  logic [3:0] s4, sq4;
  logic       co4, coq4, ov4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fa_1007 #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .in_valid(iv1),
    .s(s1), .cout(co1), .s_q(sq1), .cout_q(coq1), .out_valid(ov1)
  );

  fa_1007 #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c(c4), .in_valid(iv4),
    .s(s4), .cout(co4), .s_q(sq4), .cout_q(coq4), .out_valid(ov4)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] tbl_s;
    logic [7:0] tbl_c;
    logic [2:0] abc;
    logic [4:0] sum;
    logic [3:0] exp_sq;
    logic       exp_cq;
    logic       exp_ov;

    tbl_s = 8'b1001_0110;
    tbl_c = 8'b1110_1000;

    // reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_sq1", sq1, 0);
    chk("rst_coq1", coq1, 0);
    chk("rst_ov1", ov1, 0);
    chk("rst_sq4", sq4, 0);
    chk("rst_ov4", ov4, 0);

    // WIDTH=1 exhaustive truth table, with in_valid high while reset is held
    iv1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      abc = i[2:0];
      {a1, b1, c1} = abc;
      #1;
      chk($sformatf("tt_s_%0d", i), s1, tbl_s[i]);
      chk($sformatf("tt_cout_%0d", i), co1, tbl_c[i]);
      #4;
    end
    chk("rst_hold_sq1", sq1, 0);
    chk("rst_hold_ov1", ov1, 0);

    // release reset between edges, then a=1 b=1 c=0 valid at edge N
    iv1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; iv1 = 1'b1;
    @(negedge clk);
    chk("lat_sq", sq1, 0);
    chk("lat_coq", coq1, 1);
    chk("lat_ov", ov1, 1);

    // drop in_valid at edge N+1: data holds, valid falls
    iv1 = 1'b0;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    @(negedge clk);
    chk("hold_sq", sq1, 0);
    chk("hold_coq", coq1, 1);
    chk("hold_ov", ov1, 0);

    // capture s_q=1, then reset asynchronously between edges
    iv1 = 1'b1;
    @(negedge clk);
    chk("pre_rst_sq", sq1, 1);
    chk("pre_rst_coq", coq1, 0);
    chk("pre_rst_ov", ov1, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_sq", sq1, 0);
    chk("async_coq", coq1, 0);
    chk("async_ov", ov1, 0);
    chk("async_comb_s", s1, 1);
    chk("async_comb_cout", co1, 0);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    #1;
    chk("async_comb_s2", s1, 1);
    chk("async_comb_cout2", co1, 1);
    iv1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=4 carry-chain boundaries
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    #1;
    chk("wrap_s", s4, 8'h0);
    chk("wrap_cout", co4, 1);
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    #1;
    chk("max_s", s4, 8'hF);
    chk("max_cout", co4, 1);
    a4 = 4'h7; b4 = 4'h1; c4 = 1'b0;
    #1;
    chk("mid_s", s4, 8'h8);
    chk("mid_cout", co4, 0);

    // WIDTH=4 random vectors with random in_valid
    exp_sq = 4'h0;
    exp_cq = 1'b0;
    exp_ov = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("rnd_sq", sq4, exp_sq);
      chk("rnd_coq", coq4, exp_cq);
      chk("rnd_ov", ov4, exp_ov);
      a4  = 4'($urandom_range(0, 15));
      b4  = 4'($urandom_range(0, 15));
      c4  = 1'($urandom_range(0, 1));
      iv4 = 1'($urandom_range(0, 1));
      #1;
      sum = 5'(a4) + 5'(b4) + 5'(c4);
      chk("rnd_s", s4, sum[3:0]);
      chk("rnd_cout", co4, sum[4]);
      exp_ov = iv4;
      if (iv4) begin
        exp_sq = sum[3:0];
        exp_cq = sum[4];
      end
    end
    @(negedge clk);
    chk("rnd_last_sq", sq4, exp_sq);
    chk("rnd_last_ov", ov4, exp_ov);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
